// File: rtl/hazard_if.sv
// hazard_if: groups the pipeline-facing hazard signals of hazard_ctrl.
//   Inputs to the controller: D/E source fields, E/M/W destinations and
//   write/load flags, branchD, mduseD, mdstartE.
//   Outputs from the controller: StallF/StallD/FlushE, E and D forward
//   selects, md_busy, md_done, stall_cnt.
//   slave  : used by hazard_ctrl.
//   master : used by the pipeline (or a testbench) driving the inputs.
interface hazard_if;
    logic [4:0]  rsD, rtD;
    logic [4:0]  rsE, rtE;
    logic [4:0]  writeregE, writeregM, writeregW;
    logic        regwriteE, regwriteM, regwriteW;
    logic        memtoregE, memtoregM;
    logic        branchD;
    logic        mduseD;
    logic        mdstartE;
    logic        StallF, StallD, FlushE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        ForwardAD, ForwardBD;
    logic        md_busy;
    logic        md_done;
    logic [15:0] stall_cnt;

    modport slave (
        input  rsD, rtD, rsE, rtE,
        input  writeregE, writeregM, writeregW,
        input  regwriteE, regwriteM, regwriteW,
        input  memtoregE, memtoregM,
        input  branchD, mduseD, mdstartE,
        output StallF, StallD, FlushE,
        output ForwardAE, ForwardBE, ForwardAD, ForwardBD,
        output md_busy, md_done, stall_cnt
    );

    modport master (
        output rsD, rtD, rsE, rtE,
        output writeregE, writeregM, writeregW,
        output regwriteE, regwriteM, regwriteW,
        output memtoregE, memtoregM,
        output branchD, mduseD, mdstartE,
        input  StallF, StallD, FlushE,
        input  ForwardAE, ForwardBE, ForwardAD, ForwardBD,
        input  md_busy, md_done, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and sequencing controller for the 5-stage pipeline.
//   Produces stall (StallF/StallD) and flush (FlushE) controls, E-stage and
//   D-stage operand forwarding selects, sequences the multi-cycle mul/div
//   unit (IDLE/BUSY/DONE with a latency counter) and keeps a saturating
//   count of stalled cycles.
// Ports:
//   clk    : pipeline clock, rising edge
//   rst_n  : asynchronous active-low reset
//   hz     : hazard_if.slave bundle (see rtl/hazard_if.sv)
// Parameter:
//   MD_LAT : mul/div latency in cycles, legal range 2..16
module hazard_ctrl #(
    parameter int unsigned MD_LAT = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    hazard_if.slave  hz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_t;

    localparam logic [3:0] CNT_LOAD = 4'(MD_LAT - 1);

    md_state_t   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic lwstall, brstall, mdstall, stall;

    // Register 0 is hardwired to zero, so it never creates a dependence.
    function automatic logic hit(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

    always_comb begin
        hz.ForwardAE = 2'b00;
        hz.ForwardBE = 2'b00;
        if (hz.regwriteM && hit(hz.writeregM, hz.rsE))
            hz.ForwardAE = 2'b10;
        else if (hz.regwriteW && hit(hz.writeregW, hz.rsE))
            hz.ForwardAE = 2'b01;
        if (hz.regwriteM && hit(hz.writeregM, hz.rtE))
            hz.ForwardBE = 2'b10;
        else if (hz.regwriteW && hit(hz.writeregW, hz.rtE))
            hz.ForwardBE = 2'b01;

        hz.ForwardAD = hz.regwriteM && hit(hz.writeregM, hz.rsD);
        hz.ForwardBD = hz.regwriteM && hit(hz.writeregM, hz.rtD);
    end

    always_comb begin
        lwstall = hz.memtoregE &&
                  (hit(hz.writeregE, hz.rsD) || hit(hz.writeregE, hz.rtD));
        brstall = hz.branchD &&
                  ((hz.regwriteE &&
                    (hit(hz.writeregE, hz.rsD) || hit(hz.writeregE, hz.rtD))) ||
                   (hz.memtoregM &&
                    (hit(hz.writeregM, hz.rsD) || hit(hz.writeregM, hz.rtD))));
        mdstall = hz.mduseD && (hz.mdstartE || (state_q != IDLE));
        stall   = lwstall || brstall || mdstall;

        hz.StallF = stall;
        hz.StallD = stall;
        hz.FlushE = stall;
    end

    // MD sequencer: BUSY lasts MD_LAT cycles (cnt counts MD_LAT-1 down to 0),
    // then a single DONE cycle. mdstartE while BUSY is ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (hz.mdstartE) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0)
                    state_d = DONE;
                else
                    cnt_d = cnt_q - 4'd1;
            end
            DONE: begin
                if (hz.mdstartE) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        hz.md_busy   = (state_q != IDLE);
        hz.md_done   = (state_q == DONE);
        hz.stall_cnt = stall_cnt_q;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard and sequencing controller for the 5-stage pipeline. It generates the stall, flush and forward controls that drive the F/D/E pipeline registers: StallF to the PC, StallD to the IF/ID register, and FlushE to the ID/EX register. It also generates the operand-forwarding selects. It owns the sequencing of the multi-cycle multiply/divide unit through a small FSM with a latency counter, and keeps a saturating stall-cycle counter for performance monitoring.

## Interface
- MD_LAT, 4, multiply/divide latency in cycles; legal range 2..16.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rsD, rtD  in  5 each  source register fields of the instruction in D.
- rsE, rtE  in  5 each  source register fields of the instruction in E.
- writeregE, writeregM, writeregW  in  5 each  destination registers in E, M and W.
- regwriteE, regwriteM, regwriteW  in  1 each  destination register is written.
- memtoregE, memtoregM  in  1 each  instruction in E or M is a load.
- branchD  in  1  instruction in D is a branch or jump-register that compares in D.
- mduseD  in  1  instruction in D is mult/div/mfhi/mflo/mthi/mtlo.
- mdstartE  in  1  instruction in E starts a multiply/divide.
- StallF, StallD  out  1 each  hold the PC and the IF/ID register.
- FlushE  out  1  clear the ID/EX register.
- ForwardAE, ForwardBE  out  2 each  E-stage operand select: 00 regfile, 10 M-stage result, 01 W-stage result.
- ForwardAD, ForwardBD  out  1 each  D-stage compare operand taken from the M-stage result.
- md_busy  out  1  the MD unit is occupied (state not IDLE).
- md_done  out  1  one-cycle HI/LO write enable.
- stall_cnt  out  16  number of stalled cycles since reset.

## Operation
- Register 0 is never a hazard. Every comparison against register 0 evaluates false.
- ForwardAE: 10 if regwriteM and writeregM==rsE. Otherwise 01 if regwriteW and writeregW==rsE. Otherwise 00. M has priority over W. ForwardBE is the same using rtE.
- ForwardAD = regwriteM & writeregM==rsD. ForwardBD is the same using rtD.
- lwstall = memtoregE & (writeregE==rsD | writeregE==rtD).
- brstall = branchD & ((regwriteE & writeregE∈{rsD,rtD}) | (memtoregM & writeregM∈{rsD,rtD})).
- mdstall = mduseD & (mdstartE | state==BUSY | state==DONE).
- stall = lwstall | brstall | mdstall. StallF = StallD = FlushE = stall. All three are combinational.
- A redirect from D (nonzero PCSrcD) is suppressed by the IF/ID register while StallD is high. brstall guarantees that no branch resolves on stale operands.
- MD FSM states and transitions:
  - IDLE: if mdstartE, load cnt=MD_LAT-1 and go to BUSY.
  - BUSY: if cnt==0, go to DONE; otherwise decrement cnt.
  - DONE: md_done=1. If mdstartE, reload cnt=MD_LAT-1 and go to BUSY; otherwise go to IDLE.
- md_busy = (state != IDLE).
- mdstartE in BUSY is ignored. It cannot occur legally because mdstall holds the instruction in D.
- stall_cnt increments by 1 on every edge where stall=1. It saturates at 16'hFFFF and does not wrap.

## Timing
- Reset (rst_n low) takes effect immediately, independent of clk. state=IDLE, cnt=0, stall_cnt=0, md_busy=0, md_done=0.
- Forward and stall outputs are purely combinational from the inputs and state. They are valid in the same cycle, and reset has no effect on them.
- mdstartE sampled at edge k: BUSY for cycles k+1..k+MD_LAT, DONE in cycle k+MD_LAT+1, IDLE from cycle k+MD_LAT+2 unless restarted.
- Any mduseD stalls from the cycle mdstartE is high through the DONE cycle inclusive. It is released the cycle after DONE.
- Reset asserted mid-operation (BUSY or DONE) aborts the operation. md_done is not issued.
- Simultaneous lwstall and brstall: a single stall cycle is counted. stall_cnt counts cycles, not causes.
- Load in E with a branch in D on the same register: stall in E-cycle, then stall again while the load is in M (memtoregM). Branch compare proceeds in the following cycle with ForwardAD=0; the W value is read through the regfile write-first path.

## Test plan
- Back-to-back ALU dependence: E writes r3; the next instruction reads r3 in rsE with regwriteM=1 and writeregM=3 -> ForwardAE=10, no stall. Set writeregM=0 instead -> ForwardAE=00.
- Load-use: memtoregE=1, writeregE=5, rtD=5 -> StallF=StallD=FlushE=1 for exactly 1 cycle; stall_cnt goes 0->1.
- Branch after ALU: branchD=1, rsD=7, regwriteE=1, writeregE=7 -> 1 stall cycle, then ForwardAD=1 when the producer reaches M. With a load producer instead -> 2 stall cycles.
- Multiply, MD_LAT=4: mdstartE pulse, followed by mflo held in D -> md_busy high for 5 cycles, md_done high in the 5th cycle, StallD high for 6 cycles in total, stall_cnt=6.
- Reset mid-BUSY: deassert rst_n two cycles after mdstartE -> md_busy=0 and stall_cnt=0 immediately, md_done never pulses, and a new mdstartE after reset runs the full MD_LAT.
- Saturation: force 65540 stall cycles -> stall_cnt holds 16'hFFFF.
